// File: rtl/plug_pkg.sv
// Shared letter codes and default plugboard pairs for the forward plugboard.
// PLUG_DEFAULT_PAIRS_EN selects the six-pair reset table instead of identity.
package plug_pkg;
    localparam int CHR_W = 5;
    localparam logic [CHR_W-1:0] CHR_MIN = 5'd1;
    localparam logic [CHR_W-1:0] CHR_MAX = 5'd26;

    localparam logic [CHR_W-1:0] CHR_A = 5'd1;
    localparam logic [CHR_W-1:0] CHR_B = 5'd2;
    localparam logic [CHR_W-1:0] CHR_C = 5'd3;
    localparam logic [CHR_W-1:0] CHR_D = 5'd4;
    localparam logic [CHR_W-1:0] CHR_E = 5'd5;
    localparam logic [CHR_W-1:0] CHR_F = 5'd6;
    localparam logic [CHR_W-1:0] CHR_G = 5'd7;
    localparam logic [CHR_W-1:0] CHR_H = 5'd8;
    localparam logic [CHR_W-1:0] CHR_I = 5'd9;
    localparam logic [CHR_W-1:0] CHR_J = 5'd10;
    localparam logic [CHR_W-1:0] CHR_K = 5'd11;
    localparam logic [CHR_W-1:0] CHR_L = 5'd12;
    localparam logic [CHR_W-1:0] CHR_M = 5'd13;
    localparam logic [CHR_W-1:0] CHR_N = 5'd14;
    localparam logic [CHR_W-1:0] CHR_O = 5'd15;
    localparam logic [CHR_W-1:0] CHR_P = 5'd16;
    localparam logic [CHR_W-1:0] CHR_Q = 5'd17;
    localparam logic [CHR_W-1:0] CHR_R = 5'd18;
    localparam logic [CHR_W-1:0] CHR_S = 5'd19;
    localparam logic [CHR_W-1:0] CHR_T = 5'd20;
    localparam logic [CHR_W-1:0] CHR_U = 5'd21;
    localparam logic [CHR_W-1:0] CHR_V = 5'd22;
    localparam logic [CHR_W-1:0] CHR_W_ = 5'd23;
    localparam logic [CHR_W-1:0] CHR_X = 5'd24;
    localparam logic [CHR_W-1:0] CHR_Y = 5'd25;
    localparam logic [CHR_W-1:0] CHR_Z = 5'd26;

    // Inverse of the fixed return-path swaps
    localparam int N_DEF = 6;
    localparam logic [N_DEF-1:0][CHR_W-1:0] DEF_PA =
        {CHR_R, CHR_O, CHR_E, CHR_L, CHR_K, CHR_A};
    localparam logic [N_DEF-1:0][CHR_W-1:0] DEF_PB =
        {CHR_S, CHR_P, CHR_U, CHR_Y, CHR_M, CHR_B};

`ifdef PLUG_DEFAULT_PAIRS_EN
    localparam logic [3:0] RST_CNT = 4'd6;
`else
    localparam logic [3:0] RST_CNT = 4'd0;
`endif

    function automatic logic chr_is_valid(input logic [CHR_W-1:0] c);
        return (c >= CHR_MIN) && (c <= CHR_MAX);
    endfunction
endpackage

// File: rtl/plug_table.sv
// 32-entry involutive letter map with per-letter paired flags.
// Reset/clear contents depend on PLUG_DEFAULT_PAIRS_EN.
module plug_table
    import plug_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_add,
    input  logic [CHR_W-1:0] i_a,
    input  logic [CHR_W-1:0] i_b,
    input  logic [CHR_W-1:0] i_lk_chr,
    output logic [CHR_W-1:0] o_lk_chr,
    output logic             o_can_pair
);
    logic [31:0][CHR_W-1:0] r_map;
    logic [31:0]            r_paired;

    function automatic logic [31:0][CHR_W-1:0] init_map();
        logic [31:0][CHR_W-1:0] m;
        for (int i = 0; i < 32; i++) m[i] = CHR_W'(i);
`ifdef PLUG_DEFAULT_PAIRS_EN
        for (int k = 0; k < N_DEF; k++) begin
            m[DEF_PA[k]] = DEF_PB[k];
            m[DEF_PB[k]] = DEF_PA[k];
        end
`endif
        return m;
    endfunction

    function automatic logic [31:0] init_paired();
        logic [31:0] p;
        p = '0;
`ifdef PLUG_DEFAULT_PAIRS_EN
        for (int k = 0; k < N_DEF; k++) begin
            p[DEF_PA[k]] = 1'b1;
            p[DEF_PB[k]] = 1'b1;
        end
`endif
        return p;
    endfunction

    assign o_lk_chr = chr_is_valid(i_lk_chr) ? r_map[i_lk_chr] : i_lk_chr;

    assign o_can_pair = chr_is_valid(i_a) && chr_is_valid(i_b)
                     && (i_a != i_b)
                     && !r_paired[i_a] && !r_paired[i_b];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_map    <= init_map();
            r_paired <= init_paired();
        end else if (i_clr) begin
            r_map    <= init_map();
            r_paired <= init_paired();
        end else if (i_add) begin
            r_map[i_a]    <= i_b;
            r_map[i_b]    <= i_a;
            r_paired[i_a] <= 1'b1;
            r_paired[i_b] <= 1'b1;
        end
    end
endmodule

// File: rtl/plug_fwd.sv
// Forward-path plugboard: one registered valid/ready stage plus pair config.
// Build with PLUG_DEFAULT_PAIRS_EN to load six default pairs on reset/clear.
module plug_fwd
    import plug_pkg::*;
#(
    parameter int MAX_PAIRS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHR_W-1:0] in_chr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHR_W-1:0] out_chr,
    output logic             out_err,
    input  logic             cfg_wr,
    input  logic             cfg_clr,
    input  logic [CHR_W-1:0] cfg_a,
    input  logic [CHR_W-1:0] cfg_b,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic [3:0]       pair_cnt
);
    generate
        if (MAX_PAIRS < 1 || MAX_PAIRS > 13) begin : g_bad_max
            $error("plug_fwd: MAX_PAIRS must be 1..13");
        end
`ifdef PLUG_DEFAULT_PAIRS_EN
        if (MAX_PAIRS < N_DEF) begin : g_bad_def
            $error("plug_fwd: MAX_PAIRS too small for default pairs");
        end
`endif
    endgenerate

    logic             w_xfer;
    logic             w_full;
    logic             w_can_pair;
    logic             w_add;
    logic [CHR_W-1:0] w_lk;

    logic             r_out_valid;
    logic [CHR_W-1:0] r_out_chr;
    logic             r_out_err;
    logic             r_ack;
    logic             r_cerr;
    logic [3:0]       r_cnt;

    plug_table u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (cfg_clr),
        .i_add      (w_add),
        .i_a        (cfg_a),
        .i_b        (cfg_b),
        .i_lk_chr   (in_chr),
        .o_lk_chr   (w_lk),
        .o_can_pair (w_can_pair)
    );

    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;
    assign w_full   = (r_cnt == 4'(MAX_PAIRS));
    // Clear wins: a write in the same cycle is silently dropped
    assign w_add    = cfg_wr && !cfg_clr && w_can_pair && !w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_chr   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_chr   <= w_lk;
            r_out_err   <= !chr_is_valid(in_chr);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack  <= 1'b0;
            r_cerr <= 1'b0;
            r_cnt  <= RST_CNT;
        end else begin
            r_ack  <= w_add;
            r_cerr <= cfg_wr && !cfg_clr && !w_add;
            if (cfg_clr)
                r_cnt <= RST_CNT;
            else if (w_add)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_chr   = r_out_chr;
    assign out_err   = r_out_err;
    assign cfg_ack   = r_ack;
    assign cfg_err   = r_cerr;
    assign pair_cnt  = r_cnt;
endmodule

// File: tb/tb_plug_fwd.sv
// Self-checking bench for plug_fwd against a pair-list reference model.
// Honours PLUG_DEFAULT_PAIRS_EN the same way as the design build.
module tb_plug_fwd;
    localparam int MAXP = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_chr = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] out_chr;
    logic       out_err;
    logic       cfg_wr = 1'b0;
    logic       cfg_clr = 1'b0;
    logic [4:0] cfg_a = '0;
    logic [4:0] cfg_b = '0;
    logic       cfg_ack;
    logic       cfg_err;
    logic [3:0] pair_cnt;

    int total = 0;
    int bad = 0;

    logic [4:0] qa[$];
    logic [4:0] qb[$];

    plug_fwd #(.MAX_PAIRS(MAXP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_chr(in_chr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_chr(out_chr), .out_err(out_err),
        .cfg_wr(cfg_wr), .cfg_clr(cfg_clr),
        .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit ref_valid(logic [4:0] c);
        return (c >= 5'd1) && (c <= 5'd26);
    endfunction

    function automatic logic [4:0] ref_map(logic [4:0] c);
        foreach (qa[i]) begin
            if (qa[i] == c) return qb[i];
            if (qb[i] == c) return qa[i];
        end
        return c;
    endfunction

    function automatic bit ref_paired(logic [4:0] c);
        foreach (qa[i]) if (qa[i] == c || qb[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void ref_clear();
        qa.delete();
        qb.delete();
`ifdef PLUG_DEFAULT_PAIRS_EN
        qa.push_back(5'd1);  qb.push_back(5'd2);
        qa.push_back(5'd11); qb.push_back(5'd13);
        qa.push_back(5'd12); qb.push_back(5'd25);
        qa.push_back(5'd5);  qb.push_back(5'd21);
        qa.push_back(5'd15); qb.push_back(5'd16);
        qa.push_back(5'd18); qb.push_back(5'd19);
`endif
    endfunction

    function automatic bit ref_add(logic [4:0] a, logic [4:0] b);
        if (!ref_valid(a) || !ref_valid(b)) return 1'b0;
        if (a == b || ref_paired(a) || ref_paired(b)) return 1'b0;
        if (qa.size() >= MAXP) return 1'b0;
        qa.push_back(a);
        qb.push_back(b);
        return 1'b1;
    endfunction

    function automatic logic [4:0] next_free(logic [4:0] from);
        for (int c = int'(from); c <= 26; c++)
            if (!ref_paired(5'(c))) return 5'(c);
        return 5'd0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cfg_wr = 1'b0;
        cfg_clr = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic do_clear();
        cfg_clr = 1'b1;
        ref_clear();
        cyc();
        cfg_clr = 1'b0;
    endtask

    task automatic cfg_add(logic [4:0] a, logic [4:0] b, string nm);
        bit exp;
        exp = ref_add(a, b);
        cfg_a = a;
        cfg_b = b;
        cfg_wr = 1'b1;
        cyc();
        cfg_wr = 1'b0;
        total++;
        if (cfg_ack !== exp) begin
            bad++;
            $display("FAIL %s ack got %0b want %0b", nm, cfg_ack, exp);
        end
        total++;
        if (cfg_err !== !exp) begin
            bad++;
            $display("FAIL %s err got %0b want %0b", nm, cfg_err, !exp);
        end
        total++;
        if (pair_cnt !== 4'(qa.size())) begin
            bad++;
            $display("FAIL %s cnt got %0d want %0d", nm, pair_cnt, qa.size());
        end
        cyc();
        total++;
        if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse got %0b%0b want 00", nm, cfg_ack, cfg_err);
        end
    endtask

    task automatic send_check(logic [4:0] c, string nm);
        logic [4:0] exp;
        exp = ref_map(c);
        in_chr = c;
        in_valid = 1'b1;
        cyc();
        total++;
        if (out_valid !== 1'b1 || out_chr !== exp || out_err !== !ref_valid(c)) begin
            bad++;
            $display("FAIL %s got v=%0b c=%0d e=%0b want v=1 c=%0d e=%0b",
                     nm, out_valid, out_chr, out_err, exp, !ref_valid(c));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        ref_clear();
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_chr !== 5'd0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got v=%0b c=%0d e=%0b want 0 0 0",
                     out_valid, out_chr, out_err);
        end
        total++;
        if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_cfg got %0b%0b want 00", cfg_ack, cfg_err);
        end
        total++;
        if (pair_cnt !== 4'(qa.size())) begin
            bad++;
            $display("FAIL reset_cnt got %0d want %0d", pair_cnt, qa.size());
        end
        rst_n = 1'b1;
        cyc();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        send_check(5'd3, "basic_c");
        in_valid = 1'b0;
        send_check(5'd25, "default_y");
        in_valid = 1'b0;
        cyc();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain got %0b want 0", out_valid);
        end
    endtask

    task automatic test_pair_stream();
        do_clear();
        cfg_add(5'd1, 5'd2, "add_ab");
        send_check(5'd1, "stream_1");
        send_check(5'd2, "stream_2");
        send_check(5'd3, "stream_3");
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reject();
        logic [4:0] a;
        logic [4:0] b;
        cfg_add(5'd1, 5'd5, "rej_paired");
        cfg_add(5'd7, 5'd7, "rej_same");
        cfg_add(5'd0, 5'd3, "rej_zero");
        cfg_add(5'd4, 5'd30, "rej_hi");
        do_clear();
        while (qa.size() < MAXP) begin
            a = next_free(5'd1);
            b = next_free(a + 5'd1);
            cfg_add(a, b, "fill");
        end
        a = next_free(5'd1);
        b = next_free(a + 5'd1);
        cfg_add(a, b, "rej_full");
        send_check(a, "full_lookup");
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        logic [4:0] e1;
        e1 = ref_map(5'd1);
        out_ready = 1'b0;
        in_chr = 5'd1;
        in_valid = 1'b1;
        cyc();
        in_chr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_chr !== e1) begin
                bad++;
                $display("FAIL bp_hold%0d got r=%0b v=%0b c=%0d want 0 1 %0d",
                         i, in_ready, out_valid, out_chr, e1);
            end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got %0b want 1", in_ready);
        end
        cyc();
        total++;
        if (out_valid !== 1'b1 || out_chr !== ref_map(5'd9)) begin
            bad++;
            $display("FAIL bp_next got v=%0b c=%0d want 1 %0d",
                     out_valid, out_chr, ref_map(5'd9));
        end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_invalid();
        send_check(5'd0, "inv_0");
        send_check(5'd30, "inv_30");
        send_check(5'd26, "valid_26");
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_clr_wr();
        logic [4:0] a;
        logic [4:0] b;
        do_clear();
        a = next_free(5'd1);
        b = next_free(a + 5'd1);
        cfg_add(a, b, "pre_clr");
        cfg_a = next_free(5'd1);
        cfg_b = next_free(cfg_a + 5'd1);
        cfg_wr = 1'b1;
        cfg_clr = 1'b1;
        ref_clear();
        cyc();
        cfg_wr = 1'b0;
        cfg_clr = 1'b0;
        total++;
        if (cfg_ack !== 1'b0 || cfg_err !== 1'b0 || pair_cnt !== 4'(qa.size())) begin
            bad++;
            $display("FAIL clr_wr got ack=%0b err=%0b cnt=%0d want 0 0 %0d",
                     cfg_ack, cfg_err, pair_cnt, qa.size());
        end
        send_check(a, "clr_lookup");
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_same_cycle();
        logic [4:0] x;
        logic [4:0] y;
        do_clear();
        x = next_free(5'd1);
        y = next_free(x + 5'd1);
        in_chr = x;
        in_valid = 1'b1;
        cfg_a = x;
        cfg_b = y;
        cfg_wr = 1'b1;
        send_check(x, "old_table");
        cfg_wr = 1'b0;
        void'(ref_add(x, y));
        send_check(x, "new_table");
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        logic [4:0] x;
        logic [4:0] y;
        do_clear();
        x = next_free(5'd1);
        y = next_free(x + 5'd1);
        cfg_add(x, y, "mid_add");
        out_ready = 1'b0;
        in_chr = x;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        rst_n = 1'b0;
        ref_clear();
        #1;
        total++;
        if (out_valid !== 1'b0 || pair_cnt !== 4'(qa.size())) begin
            bad++;
            $display("FAIL mid_reset got v=%0b cnt=%0d want 0 %0d",
                     out_valid, pair_cnt, qa.size());
        end
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        send_check(x, "mid_revert");
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        bit ev;
        bit ee;
        bit ea;
        bit ec;
        logic [4:0] ech;
        idle();
        do_clear();
        cyc();
        ev = 1'b0; ee = 1'b0; ech = '0; ea = 1'b0; ec = 1'b0;
        for (int n = 0; n < 400; n++) begin
            total++;
            if (out_valid !== ev || (ev && (out_chr !== ech || out_err !== ee))) begin
                bad++;
                $display("FAIL rnd_out%0d got v=%0b c=%0d e=%0b want v=%0b c=%0d e=%0b",
                         n, out_valid, out_chr, out_err, ev, ech, ee);
            end
            total++;
            if (cfg_ack !== ea || cfg_err !== ec || pair_cnt !== 4'(qa.size())) begin
                bad++;
                $display("FAIL rnd_cfg%0d got %0b%0b cnt=%0d want %0b%0b cnt=%0d",
                         n, cfg_ack, cfg_err, pair_cnt, ea, ec, qa.size());
            end
            in_valid = ($urandom_range(0, 3) != 0);
            in_chr = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(1, 26));
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_clr = ($urandom_range(0, 49) == 0);
            cfg_wr = ($urandom_range(0, 4) == 0);
            cfg_a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(1, 26));
            cfg_b = 5'($urandom_range(1, 26));
            #1;
            total++;
            if (in_ready !== (!ev || out_ready)) begin
                bad++;
                $display("FAIL rnd_ready%0d got %0b want %0b", n, in_ready, !ev || out_ready);
            end
            if (in_valid && (!ev || out_ready)) begin
                ev = 1'b1;
                ech = ref_map(in_chr);
                ee = !ref_valid(in_chr);
            end else if (out_ready) begin
                ev = 1'b0;
            end
            ea = 1'b0;
            ec = 1'b0;
            if (cfg_clr) begin
                ref_clear();
            end else if (cfg_wr) begin
                ea = ref_add(cfg_a, cfg_b);
                ec = !ea;
            end
            cyc();
        end
        idle();
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pair_stream();
        test_reject();
        test_backpressure();
        test_invalid();
        test_clr_wr();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/plug_fwd.md
Name: plug_fwd

Overview:
- Forward-path Enigma plugboard: keyboard letter → plugboard swap → rotor entry. The return-path plugboard is the other end of the same letter path.
- Swap table is programmable and always involutive: a pair {x,y} maps x→y and y→x.
- Letter stream uses a valid/ready handshake with one registered output stage.
- Letters are 5-bit codes: a=1 … z=26. Codes 0 and 27–31 are invalid.

Parameters:
- MAX_PAIRS, 10, maximum simultaneous swap pairs; must be 1..13.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input letter valid.
- in_ready  out  1  block can accept a letter this cycle.
- in_chr  in  5  input letter code.
- out_valid  out  1  output letter valid.
- out_ready  in  1  downstream accepts the output letter.
- out_chr  out  5  plugged letter code.
- out_err  out  1  out_chr came from an invalid code and was passed through unchanged.
- cfg_wr  in  1  one-cycle request to add pair {cfg_a, cfg_b}.
- cfg_clr  in  1  one-cycle request to clear all pairs.
- cfg_a  in  5  pair letter A.
- cfg_b  in  5  pair letter B.
- cfg_ack  out  1  one-cycle pulse: pair added.
- cfg_err  out  1  one-cycle pulse: pair rejected.
- pair_cnt  out  4  number of active pairs.

Behaviour:
- Reset (async, rst_n=0):
  - Table is identity; pair_cnt=0.
  - out_valid=0, out_chr=0, out_err=0, cfg_ack=0, cfg_err=0.
  - in_ready=1 from the first cycle after release.
- Data handshake:
  - in_ready = !out_valid || out_ready. This is combinational; no combinational path from in_* to out_*.
  - Transfer occurs when in_valid && in_ready.
  - On transfer, next cycle: out_chr=table[in_chr], out_valid=1 (latency 1).
  - With out_ready held high, throughput is one letter per cycle.
  - While out_valid && !out_ready, out_chr and out_err hold stable.
  - out_valid clears when out_ready is seen and no new transfer occurs.
- Invalid input codes (0, 27–31): out_chr=in_chr, out_err=1. For valid codes out_err=0.
- Pair add (cfg_wr=1), evaluated in one cycle. Reject with cfg_err pulse, table unchanged, if any of:
  - either letter is invalid;
  - cfg_a==cfg_b;
  - either letter is already paired;
  - pair_cnt==MAX_PAIRS.
- Otherwise: table[a]=b, table[b]=a, pair_cnt+1, cfg_ack pulses the next cycle.
- Clear (cfg_clr=1): table returns to the reset contents, pair_cnt returns to its reset value, no ack pulse.
  - cfg_clr has priority over cfg_wr in the same cycle; that cfg_wr is dropped with no ack or err.
- A table update becomes visible one cycle after the cfg cycle. A letter transferred in the same cycle as a cfg write uses the old table.
- Reset asserted mid-stream discards the held output letter and any in-progress config. The table reverts.

Optional Feature:
- Macro: PLUG_DEFAULT_PAIRS_EN.
- Defined:
  - Reset (and cfg_clr) load six pairs {a,b}, {k,m}, {l,y}, {e,u}, {o,p}, {r,s}, with pair_cnt=6.
  - The forward board is then the exact inverse of the fixed return-path swaps.
  - If MAX_PAIRS<6, elaboration error.
- Undefined: reset/clear give the identity table with pair_cnt=0.

Decomposition:
- Package plug_pkg holds:
  - constants CHR_W=5, CHR_MIN=1, CHR_MAX=26;
  - letter-code localparams CHR_A…CHR_Z;
  - function chr_is_valid;
  - the default-pair list used under PLUG_DEFAULT_PAIRS_EN.
- One sub-module, plug_table: the 32-entry involutive map with per-letter "paired" flags.
  - Provides the combinational lookup port, the pair-add checker and the clear.
- plug_fwd holds the handshake register, cfg pulses and pair counter.

Test Plan:
- Reset, no config, in_chr=3 (c) → next cycle out_chr=3, out_err=0, pair_cnt=0.
- cfg_wr a=1,b=2 → cfg_ack pulse, pair_cnt=1; then stream 1,2,3 → out 2,1,3 on consecutive cycles.
- cfg_wr a=1,b=5 while {a,b} is active → cfg_err pulse, pair_cnt unchanged; also 10 pairs then an 11th → cfg_err; and cfg_a=cfg_b=7 → cfg_err.
- Hold out_ready=0 for 3 cycles after one letter → in_ready=0, out_chr stable; release → next letter accepted the same cycle.
- in_chr=0 and in_chr=30 → out_chr=0/30, out_err=1; cfg_clr together with cfg_wr → pair_cnt=0 (or 6 with macro), no ack.
- With PLUG_DEFAULT_PAIRS_EN, after reset in_chr=25 (y) → out_chr=12 (l), pair_cnt=6.
